// File: rtl/loop_gain_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_seq_pkg
// Purpose  : Shared state encodings and constants for the loop gain sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package loop_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        ACQ   = 3'd2,
        TRACK = 3'd3
    } seqState_t;

    // The most negative error has no positive twin in 8 bits; it maps to 127.
    localparam logic [7:0] c_ERR_MIN           = 8'h80;
    localparam logic [6:0] c_MAG_SAT           = 7'd127;
    localparam int         c_FLUSH_LEN_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/loop_gain_sequencer_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : run_counter
// Purpose  : Consecutive-event counter; done fires on the qualifying hit that
//            completes the run (threshold 0 acts as 1).
// Revision : 1.0 - initial release
// ============================================================================
module run_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             qualify,
    input  logic             hit,
    input  logic [CNT_W-1:0] threshold,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_inc;
    logic [CNT_W-1:0] w_eff;

    assign w_eff = (threshold == '0) ? CNT_W'(1) : threshold;
    assign w_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign done  = !clear && qualify && hit && (w_inc >= {1'b0, w_eff});

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_cnt <= '0;
        end else if (qualify) begin
            if (!hit)
                r_cnt <= '0;
            else if (w_inc[CNT_W])
                r_cnt <= '1;
            else
                r_cnt <= w_inc[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/loop_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : loop_gain_sequencer
// Purpose  : Flush / acquire / track controller driving loop-filter gains and
//            clear controls from the loop error stream.
// Revision : 1.0 - initial release
// ============================================================================
module loop_gain_sequencer
    import loop_seq_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int TO_W      = 16,
    parameter int FLUSH_LEN = c_FLUSH_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkEn,
    input  logic             errorEn,
    input  logic [7:0]       error,
    input  logic             enable,
    input  logic             restart,
    input  logic [4:0]       acqLead,
    input  logic [4:0]       acqLag,
    input  logic [4:0]       trkLead,
    input  logic [4:0]       trkLag,
    input  logic [6:0]       lockThresh,
    input  logic [CNT_W-1:0] lockCount,
    input  logic [CNT_W-1:0] unlockCount,
    input  logic [TO_W-1:0]  acqTimeout,
    output logic [4:0]       lead,
    output logic [4:0]       lag,
    output logic             zeroError,
    output logic             accumClear,
    output logic             locked,
    output logic             timeoutPulse,
    output logic [2:0]       state
);

    localparam int             FL_W         = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FL_W-1:0] c_FLUSH_LAST = FL_W'(FLUSH_LEN - 1);

    seqState_t       r_state;
    seqState_t       w_next;
    logic [FL_W-1:0] r_flushCnt;
    logic [FL_W-1:0] w_flushNext;
    logic [TO_W-1:0] r_toCnt;
    logic [TO_W-1:0] w_toNext;
    logic [TO_W:0]   w_toInc;
    logic [TO_W-1:0] w_toSat;
    logic            w_timeout;
    logic [4:0]      r_lead;
    logic [4:0]      r_lag;
    logic            r_zeroError;
    logic            r_accumClear;
    logic            r_locked;
    logic            r_timeoutPulse;
    logic [6:0]      w_mag;
    logic            w_inLock;
    logic            w_qual;
    logic            w_lockDone;
    logic            w_unlockDone;

    assign w_mag    = (error == c_ERR_MIN) ? c_MAG_SAT :
                      error[7]             ? 7'(~error[6:0] + 7'd1) : error[6:0];
    assign w_inLock = (w_mag <= lockThresh);
    assign w_qual   = clkEn && errorEn;

    assign w_toInc  = {1'b0, r_toCnt} + (TO_W+1)'(1);
    assign w_toSat  = w_toInc[TO_W] ? '1 : w_toInc[TO_W-1:0];

    // Each run counter is held clear outside the state it qualifies, so it
    // always starts from zero on entry.
    run_counter #(.CNT_W(CNT_W)) u_lockRun (
        .clk       (clk),
        .reset     (reset),
        .clear     (r_state != ACQ),
        .qualify   (w_qual),
        .hit       (w_inLock),
        .threshold (lockCount),
        .done      (w_lockDone)
    );

    run_counter #(.CNT_W(CNT_W)) u_unlockRun (
        .clk       (clk),
        .reset     (reset),
        .clear     (r_state != TRACK),
        .qualify   (w_qual),
        .hit       (!w_inLock),
        .threshold (unlockCount),
        .done      (w_unlockDone)
    );

    always_comb begin
        w_next      = r_state;
        w_flushNext = r_flushCnt;
        w_toNext    = r_toCnt;
        w_timeout   = 1'b0;
        if (!enable) begin
            w_next      = IDLE;
            w_flushNext = '0;
            w_toNext    = '0;
        end else if (restart) begin
            w_next      = FLUSH;
            w_flushNext = '0;
            w_toNext    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next      = FLUSH;
                    w_flushNext = '0;
                end
                FLUSH: begin
                    if (clkEn) begin
                        if (r_flushCnt == c_FLUSH_LAST) begin
                            w_next      = ACQ;
                            w_flushNext = '0;
                            w_toNext    = '0;
                        end else begin
                            w_flushNext = r_flushCnt + FL_W'(1);
                        end
                    end
                end
                ACQ: begin
                    // Lock takes precedence over a coincident timeout.
                    if (w_qual) begin
                        if (w_lockDone) begin
                            w_next   = TRACK;
                            w_toNext = '0;
                        end else if ((acqTimeout != '0) && (w_toInc >= {1'b0, acqTimeout})) begin
                            w_next      = FLUSH;
                            w_timeout   = 1'b1;
                            w_flushNext = '0;
                            w_toNext    = '0;
                        end else begin
                            w_toNext = w_toSat;
                        end
                    end
                end
                TRACK: begin
                    if (w_unlockDone) begin
                        w_next   = ACQ;
                        w_toNext = '0;
                    end
                end
                default: begin
                    w_next      = IDLE;
                    w_flushNext = '0;
                    w_toNext    = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_flushCnt     <= '0;
            r_toCnt        <= '0;
            r_lead         <= acqLead;
            r_lag          <= acqLag;
            r_zeroError    <= 1'b1;
            r_accumClear   <= 1'b1;
            r_locked       <= 1'b0;
            r_timeoutPulse <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_flushCnt     <= w_flushNext;
            r_toCnt        <= w_toNext;
            r_lead         <= (w_next == TRACK) ? trkLead : acqLead;
            r_lag          <= (w_next == TRACK) ? trkLag  : acqLag;
            r_zeroError    <= (w_next == IDLE) || (w_next == FLUSH);
            r_accumClear   <= (w_next == IDLE) || (w_next == FLUSH);
            r_locked       <= (w_next == TRACK);
            r_timeoutPulse <= w_timeout;
        end
    end

    assign lead         = r_lead;
    assign lag          = r_lag;
    assign zeroError    = r_zeroError;
    assign accumClear   = r_accumClear;
    assign locked       = r_locked;
    assign timeoutPulse = r_timeoutPulse;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_loop_gain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_gain_sequencer
// Purpose  : Directed plus randomized bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_gain_sequencer;

    localparam int CNT_W = 12;
    localparam int TO_W  = 16;
    localparam int FLEN  = 4;

    logic             clk = 1'b0;
    logic             reset, clkEn, errorEn, enable, restart;
    logic [7:0]       error;
    logic [4:0]       acqLead, acqLag, trkLead, trkLag;
    logic [6:0]       lockThresh;
    logic [CNT_W-1:0] lockCount, unlockCount;
    logic [TO_W-1:0]  acqTimeout;
    logic [4:0]       lead, lag;
    logic             zeroError, accumClear, locked, timeoutPulse;
    logic [2:0]       state;

    int nChecks = 0;
    int nPass   = 0;

    loop_gain_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W), .FLUSH_LEN(FLEN)) dut (
        .clk(clk), .reset(reset), .clkEn(clkEn), .errorEn(errorEn), .error(error),
        .enable(enable), .restart(restart), .acqLead(acqLead), .acqLag(acqLag),
        .trkLead(trkLead), .trkLag(trkLag), .lockThresh(lockThresh),
        .lockCount(lockCount), .unlockCount(unlockCount), .acqTimeout(acqTimeout),
        .lead(lead), .lag(lag), .zeroError(zeroError), .accumClear(accumClear),
        .locked(locked), .timeoutPulse(timeoutPulse), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 flushing, 2 acquiring, 3 tracking.
    int   mMode = 0, mGoodRun = 0, mBadRun = 0, mAcqSamples = 0, mFlushTicks = 0;
    bit   mValid = 0, mPulse = 0;
    logic [4:0] mLead, mLag;

    always @(posedge clk) begin
        int  e, mag, needLock, needUnlock;
        bit  good, q;
        logic [16:0] act, exp;
        e   = $signed(error);
        mag = (e < 0) ? -e : e;
        if (mag > 127) mag = 127;
        good       = (mag <= int'(lockThresh));
        q          = clkEn && errorEn;
        needLock   = (lockCount == 0) ? 1 : int'(lockCount);
        needUnlock = (unlockCount == 0) ? 1 : int'(unlockCount);
        mPulse = 0;
        if (!reset) begin
            mValid = 1; mMode = 0;
            mGoodRun = 0; mBadRun = 0; mAcqSamples = 0; mFlushTicks = 0;
        end else if (!enable) begin
            mMode = 0; mGoodRun = 0; mBadRun = 0; mAcqSamples = 0; mFlushTicks = 0;
        end else if (restart) begin
            mMode = 1; mGoodRun = 0; mBadRun = 0; mAcqSamples = 0; mFlushTicks = 0;
        end else if (mMode == 0) begin
            mMode = 1; mFlushTicks = 0;
        end else if (mMode == 1) begin
            if (clkEn) begin
                mFlushTicks++;
                if (mFlushTicks == FLEN) begin
                    mMode = 2; mFlushTicks = 0; mGoodRun = 0; mAcqSamples = 0;
                end
            end
        end else if (mMode == 2) begin
            if (q) begin
                mGoodRun = good ? mGoodRun + 1 : 0;
                mAcqSamples++;
                if (good && mGoodRun >= needLock) begin
                    mMode = 3; mBadRun = 0;
                end else if (acqTimeout != 0 && mAcqSamples >= int'(acqTimeout)) begin
                    mMode = 1; mPulse = 1; mFlushTicks = 0;
                end
            end
        end else begin
            if (q) begin
                mBadRun = good ? 0 : mBadRun + 1;
                if (mBadRun >= needUnlock) begin
                    mMode = 2; mGoodRun = 0; mAcqSamples = 0;
                end
            end
        end
        mLead = (mMode == 3) ? trkLead : acqLead;
        mLag  = (mMode == 3) ? trkLag  : acqLag;
        #1;
        if (mValid) begin
            act = {state, lead, lag, zeroError, accumClear, locked, timeoutPulse};
            exp = {3'(mMode), mLead, mLag, mMode < 2, mMode < 2, mMode == 3, mPulse};
            nChecks++;
            if (act === exp) nPass++;
            else $display("FAIL outputs: actual %h required %h (state %0d vs %0d) at %0t",
                          act, exp, state, mMode, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input bit ce, input bit ee, input logic [7:0] e, input int n);
        repeat (n) begin
            clkEn = ce; errorEn = ee; error = e;
            @(negedge clk);
        end
        clkEn = 0; errorEn = 0;
    endtask

    task automatic doRestart();
        restart = 1;
        @(negedge clk);
        restart = 0;
    endtask

    initial begin
        reset = 0; enable = 1; restart = 0; clkEn = 0; errorEn = 0; error = 0;
        acqLead = 5; acqLag = 2; trkLead = 12; trkLag = 9;
        lockThresh = 8; lockCount = 10; unlockCount = 4; acqTimeout = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 0);
        chk("reset_lead", 32'(lead), 5);
        chk("reset_lag", 32'(lag), 2);
        chk("reset_zero_clear", 32'({zeroError, accumClear, locked}), 32'b110);

        reset = 1;
        cyc(0, 0, 0, 1);
        chk("idle_to_flush", 32'(state), 1);
        cyc(1, 0, 0, 3);
        chk("flush_3_ticks", 32'(state), 1);
        cyc(1, 0, 0, 1);
        chk("flush_to_acq", 32'(state), 2);

        cyc(1, 1, 8'd3, 9);
        chk("acq_9_good", 32'(state), 2);
        cyc(1, 1, 8'd3, 1);
        chk("lock_state", 32'(state), 3);
        chk("lock_gains", 32'({locked, lead, lag}), 32'({1'b1, 5'd12, 5'd9}));

        cyc(1, 1, 8'hEC, 3);
        cyc(1, 1, 8'd1, 1);
        chk("track_hold", 32'({state, locked}), 32'({3'd3, 1'b1}));
        cyc(1, 1, 8'hEC, 3);
        chk("track_3_bad", 32'(state), 3);
        cyc(1, 1, 8'hEC, 1);
        chk("unlock", 32'({state, locked, zeroError, lead}), 32'({3'd2, 1'b0, 1'b0, 5'd5}));

        cyc(1, 1, 8'd3, 5);
        cyc(1, 1, 8'h80, 1);
        cyc(1, 1, 8'd3, 9);
        chk("relock_9_after_min", 32'(state), 2);
        cyc(1, 1, 8'd3, 1);
        chk("relock_10_after_min", 32'(state), 3);

        doRestart();
        chk("restart_flush", 32'({state, locked, zeroError}), 32'({3'd1, 1'b0, 1'b1}));
        acqTimeout = 50;
        cyc(1, 0, 0, 4);
        cyc(1, 1, 8'd100, 49);
        chk("to_49", 32'({state, timeoutPulse}), 32'({3'd2, 1'b0}));
        cyc(1, 1, 8'd100, 1);
        chk("to_50", 32'({state, timeoutPulse}), 32'({3'd1, 1'b1}));
        cyc(0, 0, 0, 1);
        chk("to_pulse_one_clk", 32'(timeoutPulse), 0);
        cyc(1, 0, 0, 4);
        chk("to_reacq", 32'(state), 2);
        acqTimeout = 0;
        cyc(1, 1, 8'd100, 200);
        chk("to_disabled", 32'(state), 2);

        lockCount = 20; acqTimeout = 20;
        doRestart();
        cyc(1, 0, 0, 4);
        cyc(1, 1, 8'd0, 19);
        chk("tie_19", 32'(state), 2);
        cyc(1, 1, 8'd0, 1);
        chk("tie_lock_wins", 32'({state, timeoutPulse}), 32'({3'd3, 1'b0}));

        acqTimeout = 0;
        doRestart();
        cyc(1, 0, 0, 4);
        cyc(1, 1, 8'd0, 5);
        enable = 0;
        cyc(0, 0, 0, 1);
        chk("enable_low_idle", 32'({state, zeroError}), 32'({3'd0, 1'b1}));
        enable = 1;
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 4);
        cyc(1, 1, 8'd0, 12);
        cyc(1, 0, 8'hEC, 100);
        chk("frozen", 32'(state), 2);
        cyc(1, 1, 8'd0, 7);
        chk("frozen_resume_7", 32'(state), 2);
        cyc(1, 1, 8'd0, 1);
        chk("frozen_resume_8", 32'(state), 3);

        acqLead = 7;
        reset = 0;
        cyc(0, 0, 0, 1);
        chk("reset_mid_track", 32'({state, lead, zeroError, accumClear, locked}),
            32'({3'd0, 5'd7, 1'b1, 1'b1, 1'b0}));
        reset = 1;

        for (int i = 0; i < 2500; i++) begin
            clkEn   = ($urandom_range(0, 9) < 7);
            errorEn = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) error = 8'($urandom);
            else error = 8'($signed($urandom_range(0, 20)) - 10);
            restart = ($urandom_range(0, 199) == 0);
            enable  = ($urandom_range(0, 299) != 0);
            reset   = ($urandom_range(0, 499) != 0);
            if (i % 50 == 0) begin
                acqLead = 5'($urandom); acqLag = 5'($urandom);
                trkLead = 5'($urandom); trkLag = 5'($urandom);
            end
            if (i % 200 == 0) begin
                lockThresh  = 7'($urandom_range(0, 15));
                lockCount   = CNT_W'($urandom_range(0, 12));
                unlockCount = CNT_W'($urandom_range(0, 6));
                acqTimeout  = TO_W'($urandom_range(0, 40));
            end
            @(negedge clk);
        end
        reset = 1; restart = 0; enable = 1;
        @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/loop_gain_sequencer.md
Name: loop_gain_sequencer

Overview:
Acquisition and tracking controller for the carrier/bit-sync loop filter.
- Watches the same 8-bit error stream the loop filter consumes.
- Drives the filter's lead/lag gain selects and its error-zero / accumulator-clear controls.
- Sequences flush, wide-gain acquisition, lock qualification and narrow-gain tracking, with an acquisition timeout and loss-of-lock fallback.
- Sits beside the loop filter, between the error detector and the micro register block.

Parameters:
CNT_W, 12, width of the lock/unlock run counters and their thresholds
TO_W, 16, width of the acquisition timeout counter and its threshold
FLUSH_LEN, 4, number of qualified clkEn cycles spent in FLUSH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
clkEn  in  1  loop-rate clock enable
errorEn  in  1  error sample valid; a sample is qualified when clkEn & errorEn
error  in  8  two's-complement loop error
enable  in  1  sequencer run enable
restart  in  1  single-cycle request to re-acquire
acqLead  in  5  lead gain select used in ACQ
acqLag  in  5  lag gain select used in ACQ
trkLead  in  5  lead gain select used in TRACK
trkLag  in  5  lag gain select used in TRACK
lockThresh  in  7  |error| at or below this value counts as in-lock
lockCount  in  CNT_W  consecutive in-lock samples required to declare lock
unlockCount  in  CNT_W  consecutive out-of-lock samples required to drop lock
acqTimeout  in  TO_W  samples allowed in ACQ; 0 disables the timeout
lead  out  5  gain select to loop filter
lag  out  5  gain select to loop filter
zeroError  out  1  forces the loop-filter error to zero
accumClear  out  1  clears the loop-filter lag accumulator
locked  out  1  lock indicator
timeoutPulse  out  1  one-clk pulse on acquisition timeout
state  out  3  current state, for status readback

Behaviour:
- All outputs are registered and update together with the state register.
- Reset (reset==0 at a clk edge):
  - state=IDLE; lead=acqLead, lag=acqLag (sampled at that edge).
  - zeroError=1, accumClear=1, locked=0, timeoutPulse=0.
  - All counters cleared.
- Magnitude: mag = |error|, with -128 saturated to 127. inLock = (mag <= lockThresh).
- Effective counts: lockCount=0 behaves as 1; unlockCount=0 behaves as 1.
- Priority each clk: reset > (enable==0 forces IDLE next clk) > restart (forces FLUSH next clk, counters cleared) > state transitions below.
- IDLE (0):
  - Outputs: gains=acq, zeroError=1, accumClear=1, locked=0.
  - enable==1 -> FLUSH.
- FLUSH (1):
  - Outputs: gains=acq, zeroError=1, accumClear=1, locked=0.
  - flushCnt increments on each clkEn (errorEn not required).
  - At flushCnt==FLUSH_LEN-1 with clkEn -> ACQ; goodCnt, badCnt and toCnt all cleared.
- ACQ (2):
  - Outputs: gains=acq, zeroError=0, accumClear=0, locked=0.
  - On a qualified sample: goodCnt = inLock ? goodCnt+1 : 0, saturating at its maximum; toCnt+1, saturating.
  - Lock: when goodCnt+1 reaches lockCount on an inLock sample -> TRACK, locked=1 in the same cycle as the state change.
  - Timeout: when acqTimeout!=0 and toCnt+1 reaches acqTimeout -> FLUSH, timeoutPulse=1 for one clk.
  - Lock and timeout on the same sample: lock wins, no timeoutPulse.
- TRACK (3):
  - Outputs: gains=trk, zeroError=0, accumClear=0, locked=1.
  - On a qualified sample: badCnt = inLock ? 0 : badCnt+1.
  - When badCnt+1 reaches unlockCount on an out-of-lock sample -> ACQ, with locked=0 and gains=acq.
  - No flush on this transition, so the accumulated frequency is retained.
  - goodCnt and toCnt are cleared on entry to ACQ.
- Gain inputs are live: a change to acq*/trk* inputs appears on lead/lag one clk later while in the corresponding state.
- No qualified samples: counters hold, state holds.
- Unused state encodings recover to IDLE on the next clk.

Decomposition:
- Package loop_seq_pkg contains:
  - state encodings IDLE=0, FLUSH=1, ACQ=2, TRACK=3;
  - the -128 saturation constant;
  - the default FLUSH_LEN.
- One sub-module, run_counter:
  - Parameterised CNT_W consecutive-event counter.
  - Inputs: clear, qualify, hit, threshold. Output: one-cycle done.
  - Instantiated twice, once for lock and once for unlock.
  - The timeout counter is inline in the top level.

Test Plan:
1. Reset low for 3 clk with enable=1, acqLead=5, acqLag=2 -> state=0, lead=5, lag=2, zeroError=1, accumClear=1, locked=0. Release reset -> state=1 next clk, then state=2 after 4 clkEn.
2. ACQ, lockThresh=8, lockCount=10, trkLead=12, trkLag=9:
   - 10 qualified samples of error=+3 -> state=3, locked=1, lead=12, lag=9 the clk after the 10th sample.
   - Repeat with error=0x80 injected at sample 6 -> lock occurs only after 10 further good samples.
3. TRACK, unlockCount=4:
   - error=-20 for 3 samples, then +1 -> stays locked.
   - Then 4 samples of -20 -> state=2, locked=0, zeroError stays 0.
4. acqTimeout=50, all samples error=+100:
   - timeoutPulse high exactly one clk after the 50th sample; state=1; then ACQ re-entered after 4 clkEn.
   - acqTimeout=0 -> never times out.
5. lockCount=acqTimeout=20, all samples in-lock -> TRACK reached on the 20th sample, timeoutPulse stays 0.
6. Priority and robustness:
   - restart asserted in TRACK -> FLUSH next clk, locked=0.
   - enable=0 mid-ACQ -> IDLE next clk.
   - reset low mid-TRACK -> all reset values next clk.
   - errorEn=0 for 100 clk -> counters and state frozen.
